// File: rtl/dut_core.sv
// Length-programmed 8-bit stream accumulator with an output FIFO and a cfg/status port.
// Optional build macro: SUM_SATURATE_EN (saturate the running sum at 0xFF instead of wrapping).
module dut_core #(
  parameter int DOUT_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  din_value,
  input  logic        din_en,
  output logic        din_rdy,
  input  logic        dout_en,
  output logic [7:0]  dout_value,
  output logic        dout_rdy,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  cfg_address,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_op,
  input  logic        cfg_en,
  output logic [31:0] cfg_data_out,
  output logic        cfg_rdy
);

  localparam int PTR_W = (DOUT_DEPTH > 1) ? $clog2(DOUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(DOUT_DEPTH + 1);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_LEN    = 8'h08;
  localparam logic [7:0] ADDR_COUNT  = 8'h0C;
  localparam logic [7:0] ADDR_SUM    = 8'h10;
  localparam logic [7:0] ADDR_OVF    = 8'h14;

  logic             busy_q,   busy_d;
  logic             pause_q,  pause_d;
  logic [7:0]       len_q,    len_d;
  logic [7:0]       count_q,  count_d;
  logic [7:0]       sum_q,    sum_d;
  logic             ovf_q,    ovf_d;
  logic             rdy_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q,   fill_d;
  logic [7:0]       mem [DOUT_DEPTH];

  logic       fifo_full, fifo_empty;
  logic       len_fire, din_fire, push, pop;
  logic [8:0] sum_wide;
  logic [7:0] sum_next;
  logic       cfg_wr;
  logic [31:0] rd_data;
  logic       unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_data_in[31:1];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DOUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (fill_q == CNT_W'(DOUT_DEPTH));
  assign fifo_empty = (fill_q == '0);

  assign len_rdy    = !busy_q;
  assign din_rdy    = busy_q && !pause_q && !fifo_full;
  assign dout_rdy   = !fifo_empty;
  // The array is not reset, so the head is masked while the FIFO is empty.
  assign dout_value = fifo_empty ? 8'h00 : mem[rd_ptr_q];
  assign cfg_rdy    = rdy_q;

  assign len_fire = len_en && len_rdy;
  assign din_fire = din_en && din_rdy;
  assign pop      = dout_en && dout_rdy;
  assign cfg_wr   = cfg_en && cfg_op && rdy_q;

  assign sum_wide = {1'b0, sum_q} + {1'b0, din_value};
`ifdef SUM_SATURATE_EN
  assign sum_next = sum_wide[8] ? 8'hFF : sum_wide[7:0];
`else
  assign sum_next = sum_wide[7:0];
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    busy_d   = busy_q;
    pause_d  = pause_q;
    len_d    = len_q;
    count_d  = count_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    push     = 1'b0;

    if (len_fire && (len_value != 8'h00)) begin
      len_d   = len_value;
      count_d = len_value;
      sum_d   = 8'h00;
      busy_d  = 1'b1;
    end

    if (din_fire) begin
      count_d = count_q - 8'd1;
      if (count_q == 8'd1) begin
        push   = 1'b1;
        sum_d  = 8'h00;
        busy_d = 1'b0;
      end else begin
        sum_d  = sum_next;
      end
    end

    if (cfg_wr && (cfg_address == ADDR_CTRL)) pause_d = cfg_data_in[0];
    if (cfg_wr && (cfg_address == ADDR_OVF) && cfg_data_in[0]) ovf_d = 1'b0;
    // A carry in the same cycle as a W1C clear leaves the flag set.
    if (din_fire && sum_wide[8]) ovf_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (!push && pop) fill_d = fill_q - 1'b1;
  end

  always_comb begin
    rd_data = 32'h0;
    case (cfg_address)
      ADDR_CTRL:   rd_data = {31'h0, pause_q};
      ADDR_STATUS: rd_data = {28'h0, ovf_q, fifo_empty, fifo_full, busy_q};
      ADDR_LEN:    rd_data = {24'h0, len_q};
      ADDR_COUNT:  rd_data = {24'h0, count_q};
      ADDR_SUM:    rd_data = {24'h0, sum_q};
      ADDR_OVF:    rd_data = {31'h0, ovf_q};
      default:     rd_data = 32'h0;
    endcase
  end

  assign cfg_data_out = (cfg_en && !cfg_op && rdy_q) ? rd_data : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q   <= 1'b0;
      pause_q  <= 1'b0;
      len_q    <= 8'h00;
      count_q  <= 8'h00;
      sum_q    <= 8'h00;
      ovf_q    <= 1'b0;
      rdy_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      pause_q  <= pause_d;
      len_q    <= len_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      rdy_q    <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag guards every read of it.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= sum_next;
  end

endmodule

// File: tb/tb_dut_core.sv
// Directed bench for dut_core: bursts, wrap/ovf, pause, FIFO backpressure, mid-burst reset, len=0.
module tb_dut_core;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  din_value;
  logic        din_en;
  logic        din_rdy;
  logic        dout_en;
  logic [7:0]  dout_value;
  logic        dout_rdy;
  logic [7:0]  len_value;
  logic        len_en;
  logic        len_rdy;
  logic [7:0]  cfg_address;
  logic [31:0] cfg_data_in;
  logic        cfg_op;
  logic        cfg_en;
  logic [31:0] cfg_data_out;
  logic        cfg_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dut_core #(.DOUT_DEPTH(2)) u_dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op),
    .cfg_en(cfg_en), .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    cfg_address = addr;
    cfg_op      = 1'b0;
    cfg_en      = 1'b1;
    #1;
    check(tag, cfg_data_out, exp);
    cfg_en      = 1'b0;
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
    cfg_address = addr;
    cfg_data_in = data;
    cfg_op      = 1'b1;
    cfg_en      = 1'b1;
    tick();
    cfg_en      = 1'b0;
    cfg_op      = 1'b0;
  endtask

  task automatic program_len(input logic [7:0] v);
    len_value = v;
    len_en    = 1'b1;
    tick();
    len_en    = 1'b0;
  endtask

  task automatic beat(input logic [7:0] v);
    din_value = v;
    din_en    = 1'b1;
    tick();
    din_en    = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {24'h0, dout_value}, {24'h0, exp});
    dout_en = 1'b1;
    tick();
    dout_en = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; din_value = 8'h00; din_en = 1'b0; dout_en = 1'b0;
    len_value = 8'h00; len_en = 1'b0; cfg_address = 8'h00; cfg_data_in = 32'h0;
    cfg_op = 1'b0; cfg_en = 1'b0;

    // Reset state
    #3;
    check("rst_din_rdy",  {31'h0, din_rdy},  32'h0);
    check("rst_dout_rdy", {31'h0, dout_rdy}, 32'h0);
    check("rst_dout_val", {24'h0, dout_value}, 32'h0);
    check("rst_len_rdy",  {31'h0, len_rdy},  32'h1);
    check("rst_cfg_rdy",  {31'h0, cfg_rdy},  32'h0);
    check_reg("rst_cfg_out", 8'h04, 32'h0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    check("cfg_rdy_up", {31'h0, cfg_rdy}, 32'h1);
    check_reg("idle_status", 8'h04, 32'h4);

    // Basic burst: 1+2+3
    program_len(8'd3);
    check("b1_len_rdy", {31'h0, len_rdy}, 32'h0);
    check("b1_din_rdy", {31'h0, din_rdy}, 32'h1);
    check("b1_dout_pre", {31'h0, dout_rdy}, 32'h0);
    beat(8'h01); beat(8'h02);
    check("b1_dout_mid", {31'h0, dout_rdy}, 32'h0);
    check_reg("b1_sum_mid", 8'h10, 32'h03);
    beat(8'h03);
    check("b1_dout_rdy", {31'h0, dout_rdy}, 32'h1);
    check("b1_len_rdy2", {31'h0, len_rdy},  32'h1);
    check_reg("b1_status", 8'h04, 32'h0);
    check_reg("b1_len_reg", 8'h08, 32'h3);
    pop_check("b1_result", 8'h06);
    check("b1_empty", {31'h0, dout_rdy}, 32'h0);

    // Wrap and sticky overflow
    program_len(8'd2);
    beat(8'hF0); beat(8'h20);
`ifdef SUM_SATURATE_EN
    pop_check("b2_result", 8'hFF);
`else
    pop_check("b2_result", 8'h10);
`endif
    check_reg("b2_status_ovf", 8'h04, 32'h0000_000C);
    check_reg("b2_ovf_reg", 8'h14, 32'h1);
    cfg_write(8'h04, 32'h0);
    check_reg("b2_ro_ignored", 8'h04, 32'h0000_000C);
    cfg_write(8'h14, 32'h1);
    check_reg("b2_ovf_clr", 8'h14, 32'h0);

    // Pause mid-burst
    program_len(8'd4);
    beat(8'h10); beat(8'h20);
    cfg_write(8'h00, 32'h1);
    check("b3_paused", {31'h0, din_rdy}, 32'h0);
    check_reg("b3_ctrl", 8'h00, 32'h1);
    check_reg("b3_count", 8'h0C, 32'h2);
    tick(); tick();
    check("b3_still_paused", {31'h0, din_rdy}, 32'h0);
    check_reg("b3_sum_hold", 8'h10, 32'h30);
    cfg_write(8'h00, 32'h0);
    check("b3_resumed", {31'h0, din_rdy}, 32'h1);
    beat(8'h05); beat(8'h07);
    check("b3_done_rdy", {31'h0, dout_rdy}, 32'h1);
    pop_check("b3_result", 8'h3C);

    // FIFO backpressure
    program_len(8'd1); beat(8'h11);
    program_len(8'd1); beat(8'h22);
    program_len(8'd1);
    check("b4_full_block", {31'h0, din_rdy}, 32'h0);
    check_reg("b4_status_full", 8'h04, 32'h3);
    pop_check("b4_pop1", 8'h11);
    check("b4_unblocked", {31'h0, din_rdy}, 32'h1);
    beat(8'h33);
    check_reg("b4_status_full2", 8'h04, 32'h2);
    pop_check("b4_pop2", 8'h22);
    pop_check("b4_pop3", 8'h33);
    check("b4_empty", {31'h0, dout_rdy}, 32'h0);

    // Reset mid-burst with a result queued
    program_len(8'd1); beat(8'h44);
    program_len(8'd5); beat(8'h01); beat(8'h02);
    check("b5_pre_dout", {31'h0, dout_rdy}, 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("b5_rst_dout", {31'h0, dout_rdy}, 32'h0);
    check("b5_rst_cfg",  {31'h0, cfg_rdy},  32'h0);
    check("b5_rst_din",  {31'h0, din_rdy},  32'h0);
    tick();
    RST_N = 1'b1;
    tick();
    check("b5_len_rdy", {31'h0, len_rdy}, 32'h1);
    check_reg("b5_status", 8'h04, 32'h4);
    check_reg("b5_sum", 8'h10, 32'h0);
    check_reg("b5_count", 8'h0C, 32'h0);

    // Zero length and unmapped/idle reads
    program_len(8'd0);
    check("b6_len_rdy", {31'h0, len_rdy}, 32'h1);
    check("b6_din_rdy", {31'h0, din_rdy}, 32'h0);
    tick();
    check("b6_dout_rdy", {31'h0, dout_rdy}, 32'h0);
    check_reg("b6_status", 8'h04, 32'h4);
    check_reg("b6_unmapped", 8'h40, 32'h0);
    cfg_address = 8'h04; cfg_en = 1'b0; cfg_op = 1'b0;
    #1;
    check("b6_no_en", cfg_data_out, 32'h0);
    cfg_en = 1'b1; cfg_op = 1'b1;
    #1;
    check("b6_write_op", cfg_data_out, 32'h0);
    cfg_en = 1'b0; cfg_op = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
